// File: rtl/fifo_dram_param.sv
// fifo_dram_param: flow-controlled FIFO on a dual-port RAM with a registered read port,
// occupancy count, programmable almost flags and sticky overflow/underflow errors.
module fifo_dram_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  input  logic [ADDR_W:0]   th_afull,
  input  logic [ADDR_W:0]   th_aempty,
  output logic [ADDR_W:0]   count,
  output logic              err_ovf,
  output logic              err_udf,
  input  logic              err_clr
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic              push, pop;
  // count never exceeds DEPTH, so its MSB alone marks full
  assign full         = count_q[ADDR_W];
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= th_afull;
  assign almost_empty = count_q <= th_aempty;
  assign count        = count_q;
  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign err_ovf      = ovf_q;
  assign err_udf      = udf_q;
  assign push         = wr_en && !full;
  assign pop          = rd_en && !empty;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    data_d   = pop ? ram[rd_ptr_q] : data_q;
    valid_d  = pop;
    ovf_d    = (ovf_q && !err_clr) || (wr_en && full);
    udf_d    = (udf_q && !err_clr) || (rd_en && empty);
  end
  always_ff @(posedge clk)
    if (push) ram[wr_ptr_q] <= data_in;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
endmodule

// File: tb/tb_fifo_dram_param.sv
// tb_fifo_dram_param: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_fifo_dram_param;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW:0] th_afull = 4'd6, th_aempty = 4'd1;
  logic [DW-1:0] data_out;
  logic valid_out, full, empty, almost_full, almost_empty, err_ovf, err_udf;
  logic [AW:0] count;
  int n_chk = 0, n_err = 0;
  int q[$];
  int m_dout = 0;
  bit m_valid = 0, m_ovf = 0, m_udf = 0;

  fifo_dram_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_L(reset_L), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .th_afull(th_afull),
    .th_aempty(th_aempty), .count(count), .err_ovf(err_ovf), .err_udf(err_udf),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n = q.size();
    chk({tag, ".count"}, int'(count), n);
    chk({tag, ".full"}, int'(full), int'(n == DEPTH));
    chk({tag, ".empty"}, int'(empty), int'(n == 0));
    chk({tag, ".afull"}, int'(almost_full), int'(n >= int'(th_afull)));
    chk({tag, ".aempty"}, int'(almost_empty), int'(n <= int'(th_aempty)));
    chk({tag, ".valid"}, int'(valid_out), int'(m_valid));
    chk({tag, ".dout"}, int'(data_out), m_dout);
    chk({tag, ".ovf"}, int'(err_ovf), int'(m_ovf));
    chk({tag, ".udf"}, int'(err_udf), int'(m_udf));
  endtask

  task automatic step(input string tag, input bit we, input int din, input bit re, input bit clr);
    bit was_full, was_empty;
    wr_en = we; data_in = DW'(din); rd_en = re; err_clr = clr;
    was_full = q.size() == DEPTH;
    was_empty = q.size() == 0;
    m_ovf = (m_ovf && !clr) || (we && was_full);
    m_udf = (m_udf && !clr) || (re && was_empty);
    m_valid = re && !was_empty;
    if (m_valid) m_dout = q.pop_front();
    if (we && !was_full) q.push_back(din & 8'hff);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    wr_en = 0; rd_en = 0; err_clr = 0;
    #2 reset_L = 1'b0;
    #1;
    q.delete(); m_dout = 0; m_valid = 0; m_ovf = 0; m_udf = 0;
    check_all(tag);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check_all("reset");
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    step("idle", 0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) step("fill", 1, 'h11 * i, 0, 0);
    step("ovf", 1, 'hA5, 0, 0);
    step("ovf_hold", 0, 0, 0, 0);
    step("ovf_clr", 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 1, 0);
    step("udf", 0, 0, 1, 0);
    step("pp_empty", 1, 'h3C, 1, 0);
    step("pp_empty_after", 0, 0, 0, 0);
    step("udf_clr", 0, 0, 0, 1);
    step("pp_full_prep", 1, 'h01, 0, 0);
    for (int i = 0; i < 6; i++) step("topup", 1, 'h40 + i, 0, 0);
    step("pp_full", 1, 'hEE, 1, 0);
    step("clr_vs_err", 1, 'h77, 0, 1);
    step("clr_vs_err2", 1, 'h78, 0, 1);
    step("clr", 0, 0, 0, 1);
    while (q.size() > 4) step("to4", 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step("steady", 1, 'hC0 + i, 1, 0);
    step("to5", 1, 'h55, 0, 0);
    step("mid_err", 0, 0, 1, 0);
    async_reset("midrst");
    check_all("postrst");
    step("pop_after_rst", 0, 0, 1, 0);
    step("clr2", 0, 0, 0, 1);
    for (int i = 0; i < 1600; i++) begin
      int mode = (i / 40) % 3;
      bit we = (mode == 0) ? $urandom_range(0, 3) != 0 : (mode == 1) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 1) == 1;
      bit re = (mode == 1) ? $urandom_range(0, 3) != 0 : (mode == 0) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 1) == 1;
      if (i % 100 == 0) begin
        th_afull = 4'($urandom_range(0, 10));
        th_aempty = 4'($urandom_range(0, 10));
      end
      if (i % 450 == 449) async_reset("rand_rst");
      else step("rand", we, int'($urandom_range(0, 255)), re, $urandom_range(0, 15) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
